// File: rtl/symcounter_pkg.sv
// Shared types and defaults for the multi-channel user counter slice.
package symcounter_pkg;

  // Shared run/stop control state for all channels.
  typedef enum logic {
    ST_STOPPED = 1'b0,
    ST_RUN     = 1'b1
  } run_state_e;

  // Default geometry of the counter bank.
  localparam int unsigned DEF_NUM_CH = 32'd4;
  localparam int unsigned DEF_WIDTH  = 32'd8;

endpackage

// File: rtl/updown_counter_ch.sv
// One counter channel: request qualification, up/down update with wrap or
// saturate behaviour, and sticky overflow/underflow flags.
module updown_counter_ch #(
  parameter int unsigned WIDTH       = 32'd8,
  parameter bit          SATURATE    = 1'b0,
  parameter bit          EDGE_DETECT = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clear,
  input  logic             up,
  input  logic             down,
  output logic [WIDTH-1:0] count,
  output logic             ovf,
  output logic             unf
);

  localparam logic [WIDTH-1:0] MAX_VAL  = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ZERO_VAL = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE_VAL  = {{(WIDTH-1){1'b0}}, 1'b1};

  logic             up_q_r;
  logic             down_q_r;
  logic             inc_s;
  logic             dec_s;
  logic [WIDTH-1:0] count_r;
  logic [WIDTH-1:0] count_nxt_s;
  logic             ovf_r;
  logic             ovf_nxt_s;
  logic             unf_r;
  logic             unf_nxt_s;

  // Qualify the raw button levels into single-shot or level requests.
  always_comb begin
    inc_s = 1'b0;
    dec_s = 1'b0;
    if (EDGE_DETECT) begin
      inc_s = up & ~up_q_r;
      dec_s = down & ~down_q_r;
    end else begin
      inc_s = up;
      dec_s = down;
    end
  end

  // Next count and flag values; clear beats any request, opposing requests cancel.
  always_comb begin
    count_nxt_s = count_r;
    ovf_nxt_s   = ovf_r;
    unf_nxt_s   = unf_r;
    if (clear) begin
      count_nxt_s = ZERO_VAL;
      ovf_nxt_s   = 1'b0;
      unf_nxt_s   = 1'b0;
    end else if (en && inc_s && !dec_s) begin
      if (count_r == MAX_VAL) begin
        ovf_nxt_s = 1'b1;
        if (SATURATE) begin
          count_nxt_s = MAX_VAL;
        end else begin
          count_nxt_s = ZERO_VAL;
        end
      end else begin
        count_nxt_s = count_r + ONE_VAL;
      end
    end else if (en && dec_s && !inc_s) begin
      if (count_r == ZERO_VAL) begin
        unf_nxt_s = 1'b1;
        if (SATURATE) begin
          count_nxt_s = ZERO_VAL;
        end else begin
          count_nxt_s = MAX_VAL;
        end
      end else begin
        count_nxt_s = count_r - ONE_VAL;
      end
    end else begin
      count_nxt_s = count_r;
    end
  end

  // Edge history follows the inputs every cycle, even while stopped or clearing,
  // so a press already held when counting begins is not mistaken for a new one.
  always_ff @(posedge clk) begin
    if (reset) begin
      up_q_r   <= 1'b0;
      down_q_r <= 1'b0;
    end else begin
      up_q_r   <= up;
      down_q_r <= down;
    end
  end

  // Counter value and sticky flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_r <= ZERO_VAL;
      ovf_r   <= 1'b0;
      unf_r   <= 1'b0;
    end else begin
      count_r <= count_nxt_s;
      ovf_r   <= ovf_nxt_s;
      unf_r   <= unf_nxt_s;
    end
  end

  assign count = count_r;
  assign ovf   = ovf_r;
  assign unf   = unf_r;

endmodule

// File: rtl/multi_channel_user_counter.sv
// Bank of independent up/down counters sharing one start/stop control FSM.
module multi_channel_user_counter
  import symcounter_pkg::*;
#(
  parameter int unsigned NUM_CH      = DEF_NUM_CH,
  parameter int unsigned WIDTH       = DEF_WIDTH,
  parameter bit          SATURATE    = 1'b0,
  parameter bit          EDGE_DETECT = 1'b1
) (
  input  logic                    Clk100M,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    stop,
  input  logic                    clear,
  input  logic [NUM_CH-1:0]       up,
  input  logic [NUM_CH-1:0]       down,
  output logic [NUM_CH*WIDTH-1:0] count,
  output logic                    counting,
  output logic [NUM_CH-1:0]       ovf,
  output logic [NUM_CH-1:0]       unf
);

  run_state_e state_r;
  run_state_e state_nxt_s;
  logic       run_en_s;

  // Control state register.
  always_ff @(posedge Clk100M) begin
    if (reset) begin
      state_r <= ST_STOPPED;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next control state; start wins when start and stop arrive together.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_STOPPED: begin
        if (start) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_STOPPED;
        end
      end
      ST_RUN: begin
        if (stop && !start) begin
          state_nxt_s = ST_STOPPED;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      default: begin
        state_nxt_s = ST_STOPPED;
      end
    endcase
  end

  // counting comes straight from the state flop, so a start seen at one edge
  // enables requests from the following edge onward.
  assign run_en_s = (state_r == ST_RUN);
  assign counting = run_en_s;

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    updown_counter_ch #(
      .WIDTH       (WIDTH),
      .SATURATE    (SATURATE),
      .EDGE_DETECT (EDGE_DETECT)
    ) u_ch (
      .clk   (Clk100M),
      .reset (reset),
      .en    (run_en_s),
      .clear (clear),
      .up    (up[ch]),
      .down  (down[ch]),
      .count (count[ch*WIDTH +: WIDTH]),
      .ovf   (ovf[ch]),
      .unf   (unf[ch])
    );
  end

endmodule

// File: tb/tb_multi_channel_user_counter.sv
// Randomised and directed bench for multi_channel_user_counter: a wrapping and
// a saturating instance share the same stimulus and are checked every cycle
// against an arithmetic reference model.
module tb_multi_channel_user_counter;

  localparam int NUM_CH = 4;
  localparam int WIDTH  = 8;
  localparam int MAXV   = 255;

  logic                    Clk100M = 1'b0;
  logic                    reset   = 1'b1;
  logic                    start   = 1'b0;
  logic                    stop    = 1'b0;
  logic                    clear   = 1'b0;
  logic [NUM_CH-1:0]       up      = '0;
  logic [NUM_CH-1:0]       down    = '0;

  logic [NUM_CH*WIDTH-1:0] count_w, count_s;
  logic                    counting_w, counting_s;
  logic [NUM_CH-1:0]       ovf_w, unf_w, ovf_s, unf_s;

  int tests_run    = 0;
  int tests_failed = 0;

  // reference model state: index 0 = wrapping unit, 1 = saturating unit
  int          m_cnt [2][NUM_CH];
  bit          m_ovf [2][NUM_CH];
  bit          m_unf [2][NUM_CH];
  bit          m_run;
  bit [NUM_CH-1:0] m_up_prev, m_dn_prev;

  always #5 Clk100M = ~Clk100M;

  multi_channel_user_counter #(.NUM_CH(NUM_CH), .WIDTH(WIDTH), .SATURATE(1'b0), .EDGE_DETECT(1'b1)) dut_wrap (
    .Clk100M(Clk100M), .reset(reset), .start(start), .stop(stop), .clear(clear),
    .up(up), .down(down), .count(count_w), .counting(counting_w), .ovf(ovf_w), .unf(unf_w));

  multi_channel_user_counter #(.NUM_CH(NUM_CH), .WIDTH(WIDTH), .SATURATE(1'b1), .EDGE_DETECT(1'b1)) dut_sat (
    .Clk100M(Clk100M), .reset(reset), .start(start), .stop(stop), .clear(clear),
    .up(up), .down(down), .count(count_s), .counting(counting_s), .ovf(ovf_s), .unf(unf_s));

  task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Advance the reference model by one clock edge using the inputs present at that edge.
  function automatic void model_step();
    bit inc, dec;
    if (reset) begin
      m_run = 1'b0;
      m_up_prev = '0;
      m_dn_prev = '0;
      for (int d = 0; d < 2; d++)
        for (int c = 0; c < NUM_CH; c++) begin
          m_cnt[d][c] = 0; m_ovf[d][c] = 1'b0; m_unf[d][c] = 1'b0;
        end
      return;
    end
    for (int c = 0; c < NUM_CH; c++) begin
      inc = up[c] & ~m_up_prev[c];
      dec = down[c] & ~m_dn_prev[c];
      for (int d = 0; d < 2; d++) begin
        if (clear) begin
          m_cnt[d][c] = 0; m_ovf[d][c] = 1'b0; m_unf[d][c] = 1'b0;
        end else if (m_run && inc && !dec) begin
          if (m_cnt[d][c] + 1 > MAXV) begin
            m_ovf[d][c] = 1'b1;
            m_cnt[d][c] = (d == 1) ? MAXV : 0;
          end else m_cnt[d][c] = m_cnt[d][c] + 1;
        end else if (m_run && dec && !inc) begin
          if (m_cnt[d][c] - 1 < 0) begin
            m_unf[d][c] = 1'b1;
            m_cnt[d][c] = (d == 1) ? 0 : MAXV;
          end else m_cnt[d][c] = m_cnt[d][c] - 1;
        end
      end
    end
    m_up_prev = up;
    m_dn_prev = down;
    if (start) m_run = 1'b1;
    else if (stop) m_run = 1'b0;
  endfunction

  task automatic check_outputs();
    logic [NUM_CH*WIDTH-1:0] ec [2];
    logic [NUM_CH-1:0]       eo [2];
    logic [NUM_CH-1:0]       eu [2];
    logic [WIDTH-1:0]        v;
    for (int d = 0; d < 2; d++) begin
      for (int c = 0; c < NUM_CH; c++) begin
        v = m_cnt[d][c][WIDTH-1:0];
        ec[d][c*WIDTH +: WIDTH] = v;
        eo[d][c] = m_ovf[d][c];
        eu[d][c] = m_unf[d][c];
      end
    end
    check_value("wrap_count",    count_w,    ec[0]);
    check_value("wrap_ovf",      ovf_w,      eo[0]);
    check_value("wrap_unf",      unf_w,      eu[0]);
    check_value("wrap_counting", counting_w, m_run);
    check_value("sat_count",     count_s,    ec[1]);
    check_value("sat_ovf",       ovf_s,      eo[1]);
    check_value("sat_unf",       unf_s,      eu[1]);
    check_value("sat_counting",  counting_s, m_run);
  endtask

  // One clock: model follows the edge, outputs sampled 1 ns later.
  task automatic tick();
    @(posedge Clk100M);
    model_step();
    #1;
    check_outputs();
  endtask

  task automatic pulse_up(input logic [NUM_CH-1:0] mask, input int n);
    for (int i = 0; i < n; i++) begin
      up = mask; tick();
      up = '0;   tick();
    end
  endtask

  task automatic pulse_down(input logic [NUM_CH-1:0] mask, input int n);
    for (int i = 0; i < n; i++) begin
      down = mask; tick();
      down = '0;   tick();
    end
  endtask

  initial begin
    // reset
    reset = 1'b1; tick(); tick();
    reset = 1'b0;
    check_value("rst_counting", counting_w, 1'b0);
    check_value("rst_count",    count_w,    32'h0);
    check_value("rst_ovf_unf",  {ovf_s, unf_s}, 8'h0);

    // start then three up pulses on ch0
    start = 1'b1; tick(); start = 1'b0;
    pulse_up(4'b0001, 3);
    check_value("ch0_three",    count_w[7:0],  8'd3);
    check_value("ch0_counting", counting_w,    1'b1);
    check_value("others_zero",  count_w[31:8], 24'h0);

    // climb ch1 (wrap) and ch2 (sat) to max, then one more
    pulse_up(4'b0110, 255);
    check_value("wrap_ch1_max", count_w[15:8],  8'd255);
    check_value("sat_ch2_max",  count_s[23:16], 8'd255);
    pulse_up(4'b0110, 1);
    check_value("wrap_ch1_to0", count_w[15:8],  8'd0);
    check_value("wrap_ovf1",    ovf_w[1],       1'b1);
    check_value("sat_ch2_hold", count_s[23:16], 8'd255);
    check_value("sat_ovf2",     ovf_s[2],       1'b1);
    pulse_down(4'b0010, 1);
    check_value("wrap_ch1_to255", count_w[15:8], 8'd255);
    check_value("wrap_unf1",      unf_w[1],      1'b1);

    // clear, then underflow the saturating ch2
    clear = 1'b1; tick(); clear = 1'b0;
    check_value("clr_sat_count", count_s, 32'h0);
    check_value("clr_sat_ovf",   ovf_s,   4'h0);
    pulse_down(4'b0100, 1);
    check_value("sat_ch2_hold0", count_s[23:16], 8'd0);
    check_value("sat_unf2",      unf_s[2],       1'b1);

    // gating while stopped
    stop = 1'b1; tick(); stop = 1'b0;
    pulse_up(4'b0001, 3);
    check_value("stopped_ch0",  count_w[7:0], 8'd0);
    check_value("stopped_flag", counting_w,   1'b0);

    // start and stop together -> running; held press counts once
    start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0;
    check_value("start_wins", counting_w, 1'b1);
    up = 4'b0001;
    for (int i = 0; i < 10; i++) tick();
    up = '0; tick();
    check_value("held_once", count_w[7:0], 8'd1);

    // opposing requests cancel
    pulse_up(4'b1000, 2);
    up = 4'b1000; down = 4'b1000; tick(); up = '0; down = '0; tick();
    check_value("updown_cancel", count_w[31:24], 8'd2);
    check_value("updown_noflag", {ovf_w[3], unf_w[3]}, 2'b00);

    // clear beats a same-cycle up
    clear = 1'b1; up = 4'b0001; tick(); clear = 1'b0; up = '0; tick();
    check_value("clr_count", count_w, 32'h0);
    check_value("clr_flags", {ovf_w, unf_w}, 8'h0);

    // build ch0=7 with an overflow on ch3, then reset mid-count
    pulse_up(4'b1000, 256);
    pulse_up(4'b0001, 7);
    check_value("pre_rst_ch0",  count_w[7:0], 8'd7);
    check_value("pre_rst_ovf3", ovf_w[3],     1'b1);
    reset = 1'b1; tick(); reset = 1'b0;
    check_value("mid_rst_count",    count_w,    32'h0);
    check_value("mid_rst_flags",    {ovf_w, unf_w}, 8'h0);
    check_value("mid_rst_counting", counting_w, 1'b0);

    // randomised phase
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 199) == 0);
      start = ($urandom_range(0, 15) == 0);
      stop  = ($urandom_range(0, 23) == 0);
      clear = ($urandom_range(0, 63) == 0);
      up    = NUM_CH'($urandom);
      down  = NUM_CH'($urandom);
      tick();
    end
    reset = 1'b0; start = 1'b0; stop = 1'b0; clear = 1'b0; up = '0; down = '0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
